regfile_8: RTL



---
 rtl/regfile_8_pkg.sv | 19 +
 rtl/regfile_8_rd.sv | 50 +++++
 rtl/regfile_8.sv | 84 ++++++++
 3 files changed

// File: rtl/regfile_8_pkg.sv
// Shared sizing constants and index decode for the eight-entry register file.
package regfile_8_pkg;

    localparam int RF_NREGS = 8;
    localparam int RF_AW = 3;
    localparam logic [RF_AW-1:0] RF_ZERO_IDX = '0;

    // One-hot decode of an enabled index; entry 0 never decodes, so r0 stays constant.
    function automatic logic [RF_NREGS-1:0] rf_decode(input logic en,
                                                      input logic [RF_AW-1:0] idx);
        logic [RF_NREGS-1:0] dec;
        dec = '0;
        for (int i = 1; i < RF_NREGS; i++) begin
            dec[i] = en && (idx == i[RF_AW-1:0]);
        end
        return dec;
    endfunction

endpackage

// File: rtl/regfile_8_rd.sv
// Read side of the register file: per-bit 8:1 slice mux plus writeback bypass and stall bit.
module mux_8 (
    input  logic [7:0] d,
    input  logic [2:0] sel,
    output logic       y
);

    always_comb begin
        y = d[sel];
    end

endmodule

module rf_read_port
    import regfile_8_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [RF_NREGS-1:0][WIDTH-1:0] regs,
    input  logic [RF_NREGS-1:0]            pending,
    input  logic [RF_AW-1:0]               raddr,
    input  logic                           we,
    input  logic [RF_AW-1:0]               waddr,
    input  logic [WIDTH-1:0]               wdata,
    output logic [WIDTH-1:0]               rdata,
    output logic                           busy
);

    logic [WIDTH-1:0] mux_out;
    logic             wr_match;

    for (genvar b = 0; b < WIDTH; b++) begin : g_slice
        logic [RF_NREGS-1:0] col;
        for (genvar i = 0; i < RF_NREGS; i++) begin : g_col
            assign col[i] = regs[i][b];
        end
        mux_8 u_mux (
            .d   (col),
            .sel (raddr),
            .y   (mux_out[b])
        );
    end

    assign wr_match = we && (waddr == raddr);

    // pending[0] is tied low, so index 0 never stalls and never bypasses.
    assign rdata = (wr_match && (raddr != RF_ZERO_IDX)) ? wdata : mux_out;
    assign busy  = pending[raddr] && !wr_match;

endmodule

// File: rtl/regfile_8.sv
// Eight-entry register file with pending-producer scoreboard and two bypassed read ports.
module regfile_8
    import regfile_8_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               WE,
    input  logic [RF_AW-1:0]   WADDR,
    input  logic [WIDTH-1:0]   WDATA,
    input  logic               RSV,
    input  logic [RF_AW-1:0]   RSV_ADDR,
    input  logic [RF_AW-1:0]   RADDR_A,
    input  logic [RF_AW-1:0]   RADDR_B,
    output logic [WIDTH-1:0]   RDATA_A,
    output logic [WIDTH-1:0]   RDATA_B,
    output logic               BUSY_A,
    output logic               BUSY_B
);

    logic [WIDTH-1:0]              r_q [1:RF_NREGS-1];
    logic [RF_NREGS-1:1]           pending_q;
    logic [RF_NREGS-1:0][WIDTH-1:0] regs;
    logic [RF_NREGS-1:0]           pending;
    logic [RF_NREGS-1:0]           wr_dec;
    logic [RF_NREGS-1:0]           rsv_dec;

    assign wr_dec  = rf_decode(WE, WADDR);
    assign rsv_dec = rf_decode(RSV, RSV_ADDR);

    // A same-edge reserve beats the writeback clear: the newer producer still owes a result.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 1; i < RF_NREGS; i++) begin
                r_q[i] <= '0;
            end
            pending_q <= '0;
        end else begin
            for (int i = 1; i < RF_NREGS; i++) begin
                if (wr_dec[i]) begin
                    r_q[i] <= WDATA;
                end
                if (rsv_dec[i]) begin
                    pending_q[i] <= 1'b1;
                end else if (wr_dec[i]) begin
                    pending_q[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        regs[0] = '0;
        for (int i = 1; i < RF_NREGS; i++) begin
            regs[i] = r_q[i];
        end
    end

    assign pending = {pending_q, 1'b0};

    rf_read_port #(.WIDTH(WIDTH)) u_port_a (
        .regs    (regs),
        .pending (pending),
        .raddr   (RADDR_A),
        .we      (WE),
        .waddr   (WADDR),
        .wdata   (WDATA),
        .rdata   (RDATA_A),
        .busy    (BUSY_A)
    );

    rf_read_port #(.WIDTH(WIDTH)) u_port_b (
        .regs    (regs),
        .pending (pending),
        .raddr   (RADDR_B),
        .we      (WE),
        .waddr   (WADDR),
        .wdata   (WDATA),
        .rdata   (RDATA_B),
        .busy    (BUSY_B)
    );

endmodule
